// File: rtl/gzip_trailer_checker_if.sv
// Byte-stream and check-result bundle for the GZIP trailer checker.
// The master drives payload/trailer bytes; the slave reports results.
interface gzip_trailer_checker_if;
    logic [7:0]  data_in;
    logic        data_valid_in;
    logic        trailer_valid_in;
    logic [31:0] crc32_out;
    logic [31:0] isize_out;
    logic        check_done;
    logic        check_pass;
    logic        crc_ok;
    logic        size_ok;
    logic        err_protocol;

    modport master (
        output data_in,
        output data_valid_in,
        output trailer_valid_in,
        input  crc32_out,
        input  isize_out,
        input  check_done,
        input  check_pass,
        input  crc_ok,
        input  size_ok,
        input  err_protocol
    );

    modport slave (
        input  data_in,
        input  data_valid_in,
        input  trailer_valid_in,
        output crc32_out,
        output isize_out,
        output check_done,
        output check_pass,
        output crc_ok,
        output size_ok,
        output err_protocol
    );
endinterface

// File: rtl/gzip_trailer_checker.sv
// GZIP trailer checker: running CRC32 and ISIZE of the payload,
// compared against the 8-byte little-endian trailer.
module gzip_trailer_checker #(
    parameter logic [31:0] CRC_POLY   = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    gzip_trailer_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        TRAILER,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] crc_q;
    logic [31:0] isize_q;
    logic [63:0] tsr;
    logic [3:0]  tcnt;
    logic        done_q;
    logic        pass_q;
    logic        crc_ok_q;
    logic        size_ok_q;
    logic        err_q;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic        dv;
    logic        tv;
    logic        finishing;
    logic        pay_ok;
    logic        trl_ok;
    logic        err;
    logic [31:0] crc_base;
    logic [31:0] isize_base;
    logic        crc_match;
    logic        size_match;

    assign dv = bus.data_valid_in;
    assign tv = bus.trailer_valid_in;

    // All 8 trailer bytes are in; compare on this edge.
    assign finishing = (state == TRAILER) && (tcnt == 4'd8);

    assign pay_ok = dv && !tv && (state != TRAILER);
    assign trl_ok = tv && !dv && (state != DONE) && !finishing;
    assign err    = (dv && tv)
                  || (dv && !tv && (state == TRAILER))
                  || (tv && !dv && ((state == DONE) || finishing));

    // A payload byte in DONE opens a new frame.
    assign crc_base   = (state == DONE) ? CRC_INIT : crc_q;
    assign isize_base = (state == DONE) ? 32'd0 : isize_q;

    assign crc_match  = tsr[31:0] == (crc_q ^ CRC_XOROUT);
    assign size_match = tsr[63:32] == isize_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            crc_q     <= CRC_INIT;
            isize_q   <= 32'd0;
            tsr       <= 64'd0;
            tcnt      <= 4'd0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            size_ok_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= err;
            if (finishing) begin
                done_q    <= 1'b1;
                crc_ok_q  <= crc_match;
                size_ok_q <= size_match;
                pass_q    <= crc_match && size_match;
                tcnt      <= 4'd0;
                state     <= DONE;
            end else if (pay_ok) begin
                crc_q   <= crc_byte(crc_base, bus.data_in);
                isize_q <= isize_base + 32'd1;
                state   <= PAYLOAD;
                if (state == DONE) begin
                    pass_q    <= 1'b0;
                    crc_ok_q  <= 1'b0;
                    size_ok_q <= 1'b0;
                end
            end else if (trl_ok) begin
                tsr   <= {bus.data_in, tsr[63:8]};
                tcnt  <= tcnt + 4'd1;
                state <= TRAILER;
            end
        end
    end

    assign bus.crc32_out    = crc_q ^ CRC_XOROUT;
    assign bus.isize_out    = isize_q;
    assign bus.check_done   = done_q;
    assign bus.check_pass   = pass_q;
    assign bus.crc_ok       = crc_ok_q;
    assign bus.size_ok      = size_ok_q;
    assign bus.err_protocol = err_q;

endmodule
